// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_div_unit: multi-cycle unsigned multiply/divide owning HI/LO.   |
// | Shift-add multiply and restoring divide, one bit per clock.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [4:0]       c_OP_DIV  = 5'd13;
  localparam logic [4:0]       c_OP_MULT = 5'd14;
  localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_start;
  logic [WIDTH:0]     w_psum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_start = start && ((op == c_OP_MULT) || (op == c_OP_DIV));

  // Accumulator: upper half is partial product / remainder, lower half
  // holds the multiplier or dividend bits still to be consumed.
  always_comb begin
    w_psum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_b});
    w_diff     = w_rem_sh - {1'b0, r_b};
    w_acc_next = {w_psum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_ge) w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else      w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_a      <= a;
            r_b      <= b;
            r_is_div <= (op == c_OP_DIV);
            r_acc    <= {{WIDTH{1'b0}}, ((op == c_OP_DIV) ? a : b)};
            r_cnt    <= '0;
            r_dbz    <= (op == c_OP_DIV) && (b == '0);
            r_state  <= S_RUN;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
            r_lo    <= w_acc_next[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
